// File: rtl/encoder42_sync_pkg.sv
// Shared widths, state encoding and helpers for the clocked 4-to-2 priority encoder.
// Popcount helper is only referenced when ENC42_ONEHOT_CHECK_EN is defined.
package enc_pkg;

    localparam int IN_W          = 4;
    localparam int CODE_W        = 2;
    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // True when two or more input lines are asserted at once.
    function automatic logic multi_hot(input logic [IN_W-1:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < IN_W; i++) begin
            n = n + {2'b00, v[i]};
        end
        return (n >= 3'd2);
    endfunction

endpackage

// File: rtl/encoder42_sync_if.sv
// Line-group input and encoded-output handshake bundle for encoder42_sync.
// master = producer/consumer side, slave = the encoder.
interface encoder42_sync_if #(
    parameter int CNT_W = enc_pkg::CNT_W_DEFAULT
);
    import enc_pkg::*;

    logic [IN_W-1:0]  d;
    logic             in_valid;
    logic             in_ready;
    logic             a;
    logic             b;
    logic             zero;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] cnt;
    logic             err;

    modport master (
        output d, in_valid, out_ready,
        input  in_ready, a, b, zero, out_valid, cnt, err
    );

    modport slave (
        input  d, in_valid, out_ready,
        output in_ready, a, b, zero, out_valid, cnt, err
    );

endinterface

// File: rtl/encoder42_sync_prio_enc4.sv
// Combinational 4-to-2 priority encoder; PRIO_MSB selects which end of d wins.
// The multi-hot detector is only built when ENC42_ONEHOT_CHECK_EN is defined.
module prio_enc4
    import enc_pkg::*;
#(
    parameter bit PRIO_MSB = 1'b1
) (
    input  logic [IN_W-1:0]   d,
    output logic [CODE_W-1:0] code,
    output logic              zero,
    output logic              multi
);

    always_comb begin
        code = 2'b00;
        if (PRIO_MSB) begin
            if (d[3])      code = 2'b11;
            else if (d[2]) code = 2'b10;
            else if (d[1]) code = 2'b01;
            else           code = 2'b00;
        end else begin
            if (d[0])      code = 2'b00;
            else if (d[1]) code = 2'b01;
            else if (d[2]) code = 2'b10;
            else if (d[3]) code = 2'b11;
            else           code = 2'b00;
        end
    end

    assign zero = (d == 4'b0000);

`ifdef ENC42_ONEHOT_CHECK_EN
    assign multi = multi_hot(d);
`else
    assign multi = 1'b0;
`endif

endmodule

// File: rtl/encoder42_sync.sv
// Clocked 4-to-2 priority encoder with a one-entry output slot and transfer counter.
// Optional multi-hot error flag enabled by defining ENC42_ONEHOT_CHECK_EN.
module encoder42_sync
    import enc_pkg::*;
#(
    parameter bit PRIO_MSB = 1'b1,
    parameter int CNT_W    = CNT_W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    encoder42_sync_if.slave bus
);

    state_t              state;
    state_t              state_nxt;
    logic                in_ready;
    logic                out_valid;
    logic                accept;
    logic                xfer;
    logic [CODE_W-1:0]   code;
    logic [CODE_W-1:0]   code_q;
    logic                zero_d;
    logic                zero_q;
    logic                multi;
    logic                err_q;
    logic [CNT_W-1:0]    cnt_q;

    prio_enc4 #(
        .PRIO_MSB (PRIO_MSB)
    ) u_prio_enc (
        .d     (bus.d),
        .code  (code),
        .zero  (zero_d),
        .multi (multi)
    );

    assign accept = bus.in_valid & in_ready;
    assign xfer   = out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_EMPTY;
        else        state <= state_nxt;
    end

    // A full slot drains to EMPTY only when the consumer takes it and nothing new arrives.
    always_comb begin
        state_nxt = ST_EMPTY;
        case (state)
            ST_EMPTY: state_nxt = accept ? ST_FULL : ST_EMPTY;
            ST_FULL:  state_nxt = (accept || !bus.out_ready) ? ST_FULL : ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
        case (state)
            ST_EMPTY: begin
                out_valid = 1'b0;
                in_ready  = 1'b1;
            end
            ST_FULL: begin
                out_valid = 1'b1;
                in_ready  = bus.out_ready;
            end
            default: begin
                out_valid = 1'b0;
                in_ready  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q <= '0;
            zero_q <= 1'b0;
        end else if (accept) begin
            code_q <= code;
            zero_q <= zero_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    cnt_q <= '0;
        else if (xfer) cnt_q <= cnt_q + CNT_W'(1);
    end

`ifdef ENC42_ONEHOT_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      err_q <= 1'b0;
        else if (accept) err_q <= multi;
    end
`else
    // The encoder drives multi low in this build, so err is a constant zero.
    assign err_q = multi;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.a         = code_q[1];
    assign bus.b         = code_q[0];
    assign bus.zero      = zero_q;
    assign bus.err       = err_q;
    assign bus.cnt       = cnt_q;

endmodule
